registro_digitos_param: RTL
===========================

// Module: registro_digitos_param
// PURPOSE
//  Parametrised keypad digit-entry buffer. Successor to the fixed 4-digit shift register.
//  Adds configurable depth and width, backspace, clear, enter-to-latch and overflow policy.
//  Sits between the keypad decoder (evento_tecla/tecla) and the display and compare logic.
//  Outputs the live entry and a committed value with a one-cycle valid strobe.
// PARAMETERS
//  N           4     number of digit slots (>=1)
//  W           5     bits per slot / key code width
//  BLANK       16    code stored in empty slots (display shows blank)
//  MAX_DIGIT   16    codes 0..MAX_DIGIT-1 are digits (10 = decimal-only entry)
//  KEY_BKSP    17    backspace command code
//  KEY_CLR     18    clear command code
//  KEY_ENT     19    enter/commit command code
//  OVERWRITE   1     1: digit when full shifts out oldest; 0: digit when full is rejected
//  CLR_ON_ENT  1     1: buffer clears after a successful enter
//  Constraints: MAX_DIGIT<=BLANK; BLANK, KEY_* distinct, all >=MAX_DIGIT, all <2**W.
// PORTS
//  clk            in   1                 system clock
//  reset          in   1                 synchronous reset, active-low
//  evento_tecla   in   1                 one-cycle key strobe from decoder
//  tecla          in   W                 key code, valid when evento_tecla=1
//  registro_flat  out  N*W               live slots; slot k at [k*W +: W], slot 0 = newest
//  cuenta         out  $clog2(N+1)       digits currently entered (0..N)
//  lleno          out  1                 cuenta==N
//  valor_flat     out  N*W               last committed entry, same packing
//  valor_valido   out  1                 one-cycle pulse: valor_flat just updated
//  desborde       out  1                 one-cycle pulse: digit arrived while full
// BEHAVIOUR
//  - All outputs registered. Action takes effect on the posedge where evento_tecla=1;
//    visible the following cycle. At most one action per cycle.
//  - Reset (reset=0 at posedge) dominates: all slots and valor_flat = BLANK, cuenta=0,
//    valor_valido=desborde=0. Reset mid-entry discards the entry, no strobe.
//  - Pulses (valor_valido, desborde) default 0 every cycle unless set by that cycle's action.
//  - Digit (tecla<MAX_DIGIT):
//      cuenta<N: slot[k]<=slot[k-1] (k=N-1..1), slot0<=tecla, cuenta+1.
//      cuenta==N, OVERWRITE=1: same shift, oldest lost, cuenta stays N, desborde=1.
//      cuenta==N, OVERWRITE=0: slots unchanged, desborde=1.
//  - KEY_BKSP: cuenta>0: slot[k-1]<=slot[k], slot[N-1]<=BLANK, cuenta-1. cuenta==0: no-op.
//  - KEY_CLR: all slots BLANK, cuenta=0. No strobe. Allowed at any cuenta.
//  - KEY_ENT: cuenta>0: valor_flat<=registro_flat (pre-action value), valor_valido=1;
//      if CLR_ON_ENT=1 slots cleared and cuenta=0 same edge, else buffer kept.
//      cuenta==0: ignored, no strobe, valor_flat unchanged.
//  - Any other code (BLANK, unused codes): ignored, no state change.
//  - evento_tecla=0: tecla ignored; state held.
//  - Invariant: slots with index >= cuenta hold BLANK; slots below hold digits.
//  - cuenta never exceeds N nor underflows below 0.
// TESTING (N=4, W=5, defaults)
//  1 reset=0 one cycle -> registro_flat=valor_flat=20'h84210 (all 16), cuenta=0, pulses 0.
//  2 keys 1,2,3 -> registro_flat={16,3?}: slots s3..s0 = 16,1,2,3; cuenta=3; lleno=0.
//  3 keys 1,2,3,4,5 -> s3..s0=2,3,4,5, cuenta=4, lleno=1, desborde=1 for exactly 1 cycle
//      on 5th key; repeat with OVERWRITE=0 -> s3..s0=1,2,3,4, desborde=1.
//  4 keys 7,8 then BKSP,BKSP,BKSP -> s0=7 after first, all BLANK/cuenta=0 after second,
//      third no change; then CLR at cuenta=0 -> no change.
//  5 keys 9,0 then ENT -> valor_flat s3..s0=16,16,9,0, valor_valido high 1 cycle,
//      registro cleared; ENT again at cuenta=0 -> no pulse, valor_flat held.
//  6 keys 4,5 then reset=0 coincident with evento_tecla=1,tecla=6 -> all BLANK, cuenta=0.

Source files
------------

// File: rtl/registro_digitos_param.sv
// Keypad digit-entry buffer: N slots of W bits with backspace, clear, enter-to-latch
// and a selectable full-buffer policy. Slot 0 always holds the newest digit.
module registro_digitos_param #(
  parameter int N          = 4,
  parameter int W          = 5,
  parameter int BLANK      = 16,
  parameter int MAX_DIGIT  = 16,
  parameter int KEY_BKSP   = 17,
  parameter int KEY_CLR    = 18,
  parameter int KEY_ENT    = 19,
  parameter int OVERWRITE  = 1,
  parameter int CLR_ON_ENT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   evento_tecla,
  input  logic [W-1:0]           tecla,
  output logic [N*W-1:0]         registro_flat,
  output logic [$clog2(N+1)-1:0] cuenta,
  output logic                   lleno,
  output logic [N*W-1:0]         valor_flat,
  output logic                   valor_valido,
  output logic                   desborde
);

  localparam int CW = $clog2(N+1);
  localparam logic [W-1:0]  BLANK_C = W'(BLANK);
  localparam logic [W-1:0]  DIG_C   = W'(MAX_DIGIT);
  localparam logic [W-1:0]  BKSP_C  = W'(KEY_BKSP);
  localparam logic [W-1:0]  CLR_C   = W'(KEY_CLR);
  localparam logic [W-1:0]  ENT_C   = W'(KEY_ENT);
  localparam logic [CW-1:0] N_C     = CW'(N);

  logic [N*W-1:0] all_blank;
  logic [N*W-1:0] registro_n;
  logic [N*W-1:0] valor_n;
  logic [CW-1:0]  cuenta_n;
  logic           valor_valido_n;
  logic           desborde_n;

  always_comb begin
    for (int k = 0; k < N; k++) all_blank[k*W +: W] = BLANK_C;
  end

  // Next-state decode: at most one key action per cycle
  always_comb begin
    registro_n     = registro_flat;
    valor_n        = valor_flat;
    cuenta_n       = cuenta;
    valor_valido_n = 1'b0;
    desborde_n     = 1'b0;
    if (evento_tecla) begin
      if (tecla < DIG_C) begin
        if (cuenta != N_C || OVERWRITE != 0) begin
          for (int k = N-1; k >= 1; k--) registro_n[k*W +: W] = registro_flat[(k-1)*W +: W];
          registro_n[0 +: W] = tecla;
        end
        if (cuenta != N_C) cuenta_n = cuenta + CW'(1);
        else               desborde_n = 1'b1;
      end else if (tecla == BKSP_C) begin
        if (cuenta != '0) begin
          for (int k = 0; k < N-1; k++) registro_n[k*W +: W] = registro_flat[(k+1)*W +: W];
          registro_n[(N-1)*W +: W] = BLANK_C;
          cuenta_n = cuenta - CW'(1);
        end
      end else if (tecla == CLR_C) begin
        registro_n = all_blank;
        cuenta_n   = '0;
      end else if (tecla == ENT_C) begin
        if (cuenta != '0) begin
          valor_n        = registro_flat;
          valor_valido_n = 1'b1;
          if (CLR_ON_ENT != 0) begin
            registro_n = all_blank;
            cuenta_n   = '0;
          end
        end
      end
    end
  end

  // Register stage: reset discards any entry and suppresses strobes
  always_ff @(posedge clk) begin
    if (!reset) begin
      registro_flat <= all_blank;
      valor_flat    <= all_blank;
      cuenta        <= '0;
      lleno         <= 1'b0;
      valor_valido  <= 1'b0;
      desborde      <= 1'b0;
    end else begin
      registro_flat <= registro_n;
      valor_flat    <= valor_n;
      cuenta        <= cuenta_n;
      lleno         <= (cuenta_n == N_C);
      valor_valido  <= valor_valido_n;
      desborde      <= desborde_n;
    end
  end

endmodule
